// File: rtl/ecc_pkg.sv
// Shared constants and types for the SECDED memory controller.
// Widths, check-bit positions and controller state encoding.
package ecc_pkg;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 39;
    localparam int CNTW = 16;
    localparam int NCHK = 6;

    localparam int CHK_POS [NCHK] = '{1, 2, 4, 8, 16, 32};

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        SCRUB,
        RESP
    } state_t;

endpackage

// File: rtl/ecc_secded.sv
// Combinational Hamming SECDED (39,32) encoder and decoder.
// Codeword bit i carries Hamming position i+1; bit 38 is overall parity.
module ecc_secded
    import ecc_pkg::*;
(
    input  logic [DW-1:0] enc_data,
    output logic [CW-1:0] enc_cw,
    input  logic [CW-1:0] dec_cw,
    output logic [DW-1:0] dec_data,
    output logic [DW-1:0] raw_data,
    output logic [CW-1:0] corr_cw,
    output logic          single_err,
    output logic          multi_err
);

    function automatic logic is_chk(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [CW-1:0] insert(input logic [DW-1:0] d);
        logic [CW-1:0] w;
        int k;
        w = '0;
        k = 0;
        for (int p = 1; p < CW; p++) begin
            if (!is_chk(p)) begin
                w[p-1] = d[k];
                k++;
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] w);
        logic [DW-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p < CW; p++) begin
            if (!is_chk(p)) begin
                d[k] = w[p-1];
                k++;
            end
        end
        return d;
    endfunction

    // Syndrome is the XOR of the positions of all set bits 1..38.
    function automatic logic [NCHK-1:0] syn(input logic [CW-1:0] w);
        logic [NCHK-1:0] s;
        s = '0;
        for (int p = 1; p < CW; p++) begin
            if (w[p-1]) s = s ^ NCHK'(p);
        end
        return s;
    endfunction

    logic [CW-1:0]   ew;
    logic [NCHK-1:0] es;
    logic [NCHK-1:0] ds;
    logic            dp;

    always_comb begin
        ew = insert(enc_data);
        es = syn(ew);
        for (int c = 0; c < NCHK; c++) begin
            ew[CHK_POS[c]-1] = es[c];
        end
        ew[CW-1] = ^ew[CW-2:0];
        enc_cw = ew;
    end

    always_comb begin
        ds         = syn(dec_cw);
        dp         = ^dec_cw;
        corr_cw    = dec_cw;
        single_err = 1'b0;
        multi_err  = 1'b0;
        if (dp) begin
            if (ds <= NCHK'(CW - 1)) begin
                single_err = 1'b1;
                if (ds == '0) corr_cw[CW-1] = ~dec_cw[CW-1];
                for (int q = 1; q < CW; q++) begin
                    if (NCHK'(q) == ds) corr_cw[q-1] = ~dec_cw[q-1];
                end
            end else begin
                multi_err = 1'b1;
            end
        end else if (ds != '0) begin
            multi_err = 1'b1;
        end
        dec_data = extract(corr_cw);
        raw_data = extract(dec_cw);
    end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// Load/store controller that protects data memory with SECDED,
// scrubs corrected words back and keeps error statistics.
module ecc_mem_ctrl
    import ecc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_in,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [CW-1:0]   mem_wd,
    input  logic [CW-1:0]   mem_rd,
    output logic [CNTW-1:0] ce_count,
    output logic [CNTW-1:0] ue_count,
    output logic [AW-1:0]   err_addr
);

    state_t state, state_n;

    logic [CW-1:0] enc_cw;
    logic [DW-1:0] dec_data;
    logic [DW-1:0] raw_data;
    logic [CW-1:0] corr_cw;
    logic          single_err;
    logic          multi_err;

    ecc_secded u_secded (
        .enc_data   (req_wdata),
        .enc_cw     (enc_cw),
        .dec_cw     (mem_rd),
        .dec_data   (dec_data),
        .raw_data   (raw_data),
        .corr_cw    (corr_cw),
        .single_err (single_err),
        .multi_err  (multi_err)
    );

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (req_valid) state_n = req_we ? WRITE : READ;
            WRITE: state_n = IDLE;
            READ:  state_n = single_err ? SCRUB : RESP;
            SCRUB: state_n = RESP;
            RESP:  if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // req_ready is gated by reset so it reads 0 while reset is held.
    assign req_ready = rst_in && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_we    = (state == WRITE) || (state == SCRUB);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            mem_addr  <= '0;
            mem_wd    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ce_count  <= '0;
            ue_count  <= '0;
            err_addr  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                mem_addr <= req_addr;
                if (req_we) mem_wd <= enc_cw;
            end
            if (state == READ) begin
                rsp_rdata <= multi_err ? raw_data : dec_data;
                rsp_err   <= multi_err;
                mem_wd    <= corr_cw;
                if (single_err) begin
                    if (ce_count != '1) ce_count <= ce_count + 1'b1;
                    err_addr <= mem_addr;
                end
                if (multi_err) begin
                    if (ue_count != '1) ue_count <= ue_count + 1'b1;
                    err_addr <= mem_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Self-checking bench for ecc_mem_ctrl: directed vector table,
// multi-cycle corner sequences and randomized loads with injected errors.
module tb_ecc_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [38:0] mem_wd;
    logic [38:0] mem_rd;
    logic [15:0] ce_count;
    logic [15:0] ue_count;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    ecc_mem_ctrl dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .ce_count  (ce_count),
        .ue_count  (ue_count),
        .err_addr  (err_addr)
    );

    logic [38:0] mem [16];
    logic        inj_en = 1'b0;
    logic [3:0]  inj_addr = '0;
    logic [38:0] inj_val = '0;
    int          we_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [38:0] last_wd = '0;

    assign mem_rd = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[3:0]] <= mem_wd;
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wd;
        end else if (inj_en) begin
            mem[inj_addr] <= inj_val;
        end
    end

    int checks = 0;
    int failures = 0;

    logic [31:0] mdata [16];
    logic [38:0] mflip [16];
    int          exp_ce = 0;
    int          exp_ue = 0;
    logic [31:0] exp_ea = '0;

    // Check bit at position 2^j is the even parity of every covered position.
    function automatic logic [38:0] ref_enc(input logic [31:0] d);
        logic [38:0] c;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!$onehot(pos)) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 6; j++) begin
            logic x;
            x = 1'b0;
            for (int pos = 1; pos <= 38; pos++) begin
                if (((pos >> j) & 1) == 1) x = x ^ c[pos-1];
            end
            c[(1 << j) - 1] = x;
        end
        c[38] = ^c[37:0];
        return c;
    endfunction

    function automatic logic [31:0] ref_extract(input logic [38:0] c);
        logic [31:0] d;
        int k;
        d = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!$onehot(pos)) begin
                d[k] = c[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic poke(input int a, input logic [38:0] v);
        @(negedge clk);
        inj_en   = 1'b1;
        inj_addr = a[3:0];
        inj_val  = v;
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic store(input int a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'(a);
        req_wdata = d;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        chk("st_we_hi", mem_we, 1);
        chk("st_wd", mem_wd, ref_enc(d));
        @(negedge clk);
        chk("st_we_lo", mem_we, 0);
        chk("st_rdy", req_ready, 1);
        mdata[a] = d;
        mflip[a] = '0;
    endtask

    task automatic load(input int a, output logic [31:0] rd,
                        output logic er, output int lat, output int wed);
        int w0;
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'(a);
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wed = we_cnt - w0;
    endtask

    // Loads address a and compares against the model, then updates it.
    task automatic load_model(input int a);
        logic [31:0] rd, erd;
        logic        er, eer;
        int          lat, wed, elat, ewe, nf;
        nf = $countones(mflip[a]);
        erd = mdata[a];
        eer = 1'b0;
        elat = 2;
        ewe = 0;
        if (nf == 1) begin
            elat = 3;
            ewe = 1;
            exp_ce++;
            exp_ea = 32'(a);
        end else if (nf == 2) begin
            erd = ref_extract(ref_enc(mdata[a]) ^ mflip[a]);
            eer = 1'b1;
            exp_ue++;
            exp_ea = 32'(a);
        end
        load(a, rd, er, lat, wed);
        chk("ld_rdata", rd, erd);
        chk("ld_err", er, eer);
        chk("ld_lat", lat, elat);
        chk("ld_we", wed, ewe);
        if (ewe == 1) begin
            chk("scrub_addr", last_wa, 32'(a));
            chk("scrub_data", last_wd, ref_enc(mdata[a]));
            mflip[a] = '0;
        end
        chk("ce_count", ce_count, exp_ce);
        chk("ue_count", ue_count, exp_ue);
        chk("err_addr", err_addr, exp_ea);
    endtask

    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] wdata;
        bit          pre;
        logic [38:0] pre_cw;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
        int          exp_we;
        int          exp_ce;
        int          exp_ue;
        int          exp_ea;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [31:0] rd, r0;
        logic        er;
        int          lat, wed, w0, a, b1, b2;

        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 39'h0, 32'h0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 5, 32'h0, 0, 39'h0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 0};
        tbl[2] = '{0, 3, 32'h0, 1, 39'h4, 32'h0, 0, 3, 1, 1, 0, 3};
        tbl[3] = '{0, 7, 32'h0, 1, 39'h3, 32'h0, 1, 2, 0, 1, 1, 7};
        tbl[4] = '{0, 3, 32'h0, 0, 39'h0, 32'h0, 0, 2, 0, 1, 1, 7};

        for (int i = 0; i < 16; i++) begin
            mdata[i] = '0;
            mflip[i] = '0;
            poke(i, 39'h0);
        end
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_counts", {ce_count, ue_count}, 0);
        chk("rst_regs", {mem_addr, err_addr}, 0);
        chk("rst_wd", mem_wd, 0);
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 1);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pre) poke(tbl[i].addr, tbl[i].pre_cw);
            if (tbl[i].we) begin
                store(tbl[i].addr, tbl[i].wdata);
            end else begin
                load(tbl[i].addr, rd, er, lat, wed);
                chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
                chk($sformatf("v%0d_err", i), er, tbl[i].exp_err);
                chk($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
                chk($sformatf("v%0d_we", i), wed, tbl[i].exp_we);
                chk($sformatf("v%0d_ce", i), ce_count, tbl[i].exp_ce);
                chk($sformatf("v%0d_ue", i), ue_count, tbl[i].exp_ue);
                chk($sformatf("v%0d_ea", i), err_addr, tbl[i].exp_ea);
                if (tbl[i].exp_we == 1) begin
                    chk($sformatf("v%0d_wa", i), last_wa, tbl[i].addr);
                    chk($sformatf("v%0d_wd", i), last_wd, ref_enc(tbl[i].exp_rd));
                end
            end
        end
        mdata[7] = '0;
        mflip[7] = 39'h3;
        exp_ce = 1;
        exp_ue = 1;
        exp_ea = 32'd7;

        // Response held off for four cycles must stay stable.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd5;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r0 = rsp_rdata;
        chk("stall_first", r0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("stall_err", rsp_err, 0);
            chk("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_release", req_ready, 1);

        for (int n = 0; n < 150; n++) begin
            a = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                store(a, $urandom);
            end else begin
                if (mflip[a] == '0) begin
                    b1 = int'($urandom_range(0, 38));
                    b2 = (b1 + int'($urandom_range(1, 38))) % 39;
                    case ($urandom_range(0, 2))
                        1: mflip[a][b1] = 1'b1;
                        2: begin
                            mflip[a][b1] = 1'b1;
                            mflip[a][b2] = 1'b1;
                        end
                        default: ;
                    endcase
                    if (mflip[a] != '0) poke(a, ref_enc(mdata[a]) ^ mflip[a]);
                end
                load_model(a);
            end
        end

        // Reset pulled during SCRUB aborts the write-back.
        mflip[9] = 39'h10;
        poke(9, ref_enc(mdata[9]) ^ mflip[9]);
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd9;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("scrub_we_hi", mem_we, 1);
        #1;
        rst_in = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_valid", rsp_valid, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_err", rsp_err, 0);
        chk("arst_rdata", rsp_rdata, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wd", mem_wd, 0);
        chk("arst_cnt", {ce_count, ue_count}, 0);
        chk("arst_ea", err_addr, 0);
        @(negedge clk);
        rst_in = 1'b1;
        #1;
        chk("arst_rel_ready", req_ready, 1);
        chk("arst_no_write", we_cnt, w0);
        exp_ce = 0;
        exp_ue = 0;
        exp_ea = '0;
        load_model(9);
        store(2, 32'h1234_5678);
        load_model(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ecc_mem_ctrl.md
ECC_MEM_CTRL -- requirements
Module: ecc_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1: core request present.
REQ-004 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both high.
REQ-005 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 32: word index.
REQ-007 SHALL have port req_wdata, input, 32: store data.
REQ-008 SHALL have port rsp_valid, output, 1: load response present.
REQ-009 SHALL have port rsp_ready, input, 1: core accepts the response.
REQ-010 SHALL have port rsp_rdata, output, 32: load data, corrected where possible.
REQ-011 SHALL have port rsp_err, output, 1: uncorrectable error on this load.
REQ-012 SHALL have port mem_we, output, 1: data-memory write enable.
REQ-013 SHALL have port mem_addr, output, 32: data-memory word address.
REQ-014 SHALL have port mem_wd, output, 39: codeword to data memory.
REQ-015 SHALL have port mem_rd, input, 39: combinational codeword from data memory at mem_addr.
REQ-016 SHALL have port ce_count, output, 16: corrected-error count, saturating.
REQ-017 SHALL have port ue_count, output, 16: uncorrectable-error count, saturating.
REQ-018 SHALL have port err_addr, output, 32: address of the most recent error, either class.

Function
REQ-019 SHALL implement a finite state machine with states IDLE, WRITE, READ, SCRUB and RESP.
REQ-020 SHALL assert req_ready only in IDLE.
REQ-021 SHALL, on a store accept, register the address and the encoded codeword and go to WRITE.
REQ-022 SHALL, in WRITE, hold mem_we=1 for exactly one cycle, then return to IDLE; a store produces no response.
REQ-023 SHALL, on a load accept, register the address and go to READ.
REQ-024 SHALL, in READ, decode mem_rd and register the decoded data, rsp_err and the corrected codeword.
- No error or uncorrectable error: go to RESP.
- Single-bit error: go to SCRUB.
REQ-025 SHALL, in SCRUB, write the corrected codeword back (mem_we=1, one cycle), then go to RESP.
REQ-026 SHALL, in RESP, hold rsp_valid=1 with stable rsp_rdata and rsp_err until rsp_ready=1, then return to IDLE.
REQ-027 SHALL drive mem_addr from the registered address in every state, so the read address is stable during READ.
REQ-028 SHALL meet these load latencies from the accept edge:
- Clean load: rsp_valid first high 2 cycles later.
- Corrected load: rsp_valid first high 3 cycles later.
REQ-029 SHALL encode with Hamming SECDED (39,32):
- Bit i holds Hamming position i+1 for positions 1..38.
- Check bits sit at positions 1, 2, 4, 8, 16 and 32.
- Data bits d0..d31 fill the remaining positions in ascending order.
- Bit 38 is the even parity of bits [37:0].
REQ-030 SHALL decode with syndrome s (6 bits) and overall-parity mismatch P:
- s=0, P=0: clean.
- P=1, s<=38: single-bit error at position s; s=0 means bit 38. Correct it.
- P=0, s!=0: uncorrectable.
- P=1, s>38: uncorrectable.
REQ-031 SHALL, on an uncorrectable error, return the raw data bits unmodified with rsp_err=1, and SHALL NOT scrub.
REQ-032 SHALL increment ce_count or ue_count once per erroneous load, saturating at 16'hFFFF, and update err_addr in the same cycle.

Reset
REQ-033 SHALL, while rst_in=0, immediately force:
- State to IDLE.
- mem_we, rsp_valid, rsp_err, req_ready to 0.
- rsp_rdata, mem_addr, mem_wd, ce_count, ue_count, err_addr to 0.
REQ-034 SHALL, when reset occurs mid-WRITE or mid-SCRUB, abort the write with no retry; a pending response is discarded.
REQ-035 SHALL assert req_ready in the first cycle after rst_in rises.

Structure
REQ-036 SHALL place the FSM state encoding, the widths (32/39/16) and the check-bit position constants in shared package ecc_pkg.
REQ-037 SHALL put encode and decode in one combinational sub-module, ecc_secded; the controller holds only the FSM, registers and counters.

Verification
REQ-038 Store 32'hDEADBEEF at address 5, then load address 5 -> rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid 2 cycles after the load accept, counters remain 0.
REQ-039 Preload mem[3]=39'h0000000004 (data bit 0 flipped), load address 3 -> rsp_rdata=0, rsp_err=0, ce_count=1, err_addr=3, a one-cycle mem_we writing 39'h0 to address 3, rsp_valid 3 cycles after the accept.
REQ-040 Preload mem[7]=39'h0000000003 (double error), load address 7 -> rsp_err=1, ue_count=1, err_addr=7, no mem_we.
REQ-041 Hold rsp_ready=0 for 4 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; after one cycle with rsp_ready=1 -> req_ready=1 the following cycle.
REQ-042 Pull rst_in low during SCRUB -> mem_we drops in the same cycle, all outputs read 0, and the controller accepts a new request after release.
